// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with fill-level IRQ, first-word-fall-through read port.
// Optional idle-timeout interrupt is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int IRQ_THRESH    = 8,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clken,
  input  logic [7:0]            i_din_8b,
  input  logic                  i_din_valid,
  input  logic                  i_rd_en,
  output logic [7:0]            o_dout_8b,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  input  logic                  i_clr_ovf,
  output logic                  o_overflow,
  output logic                  o_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] IRQ_LVL  = CW'(IRQ_THRESH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;
  logic                  push, pop, drop;
  logic                  tmo_irq;

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  always_comb begin
    pop  = i_rd_en & ~empty_q;
    push = i_din_valid & (~full_q | pop);
    drop = i_din_valid & full_q & ~pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_LVL);
    ovf_d   = drop | (ovf_q & ~i_clr_ovf);
    irq_d   = (count_d >= IRQ_LVL) | tmo_irq;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is suppressed.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr_q] <= i_din_8b;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LVL = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_flag_q, tmo_flag_d;

  // Counter saturates at the limit; the flag holds until the next push or pop.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (push || pop || empty_q) begin
      tmo_cnt_d = '0;
    end else if (i_clken && (tmo_cnt_q != TMO_LVL)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    tmo_flag_d = (push | pop) ? 1'b0 : (tmo_flag_q | (tmo_cnt_d == TMO_LVL));
    tmo_irq    = tmo_flag_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = i_clken ^ (TIMEOUT_TICKS > 0);
  assign tmo_irq        = 1'b0;
`endif

  assign o_dout_8b  = mem[rd_ptr_q];
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_irq      = irq_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2^DEPTH_LOG2 bytes (16).
REQ-002 SHALL have parameter IRQ_THRESH, default 8, the fill level at which the level interrupt asserts.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 640, the number of i_clken ticks before idle timeout (4 chars x 10 bits x 16).
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_clken  input  1  16x-baud sample tick shared with the receiver.
REQ-007 SHALL have port i_din_8b  input  8  received byte from the UART receiver.
REQ-008 SHALL have port i_din_valid  input  1  one-cycle strobe qualifying i_din_8b.
REQ-009 SHALL have port i_rd_en  input  1  pop strobe from the peripheral register read.
REQ-010 SHALL have port o_dout_8b  output  8  head-of-FIFO byte, first-word-fall-through.
REQ-011 SHALL have port o_empty  output  1  FIFO holds zero bytes.
REQ-012 SHALL have port o_full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-013 SHALL have port o_count  output  DEPTH_LOG2+1  current fill level.
REQ-014 SHALL have port i_clr_ovf  input  1  clears the sticky overflow flag.
REQ-015 SHALL have port o_overflow  output  1  sticky; a byte was dropped.
REQ-016 SHALL have port o_irq  output  1  level interrupt, OR of threshold and timeout conditions.

Function
REQ-017 SHALL push i_din_8b when i_din_valid=1 and o_full=0; pointer and count update at that edge.
REQ-018 SHALL drop the byte and set o_overflow when i_din_valid=1 and o_full=1 with no pop in the same cycle.
REQ-019 SHALL pop when i_rd_en=1 and o_empty=0; i_rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-020 SHALL, on push and pop in the same cycle while full, perform both: count unchanged, no overflow.
REQ-021 SHALL, on push and pop in the same cycle while empty, accept the push and ignore the pop: count becomes 1.
REQ-022 SHALL, on push and pop in the same cycle otherwise, perform both with count unchanged.
REQ-023 SHALL present a pushed byte on o_dout_8b, with o_empty=0, in the cycle after the push edge (1-cycle latency).
REQ-024 SHALL show the next entry on o_dout_8b in the cycle after a pop edge; o_dout_8b is don't-care while empty.
REQ-025 SHALL use DEPTH_LOG2-bit read/write pointers that wrap modulo depth; full/empty SHALL derive from o_count, not pointer equality.
REQ-026 SHALL register o_empty, o_full and o_count, consistent with each other every cycle.
REQ-027 SHALL, when i_clr_ovf and a new overflow event coincide, keep o_overflow=1 (set wins).
REQ-028 SHALL assert the level term of o_irq, registered, while o_count >= IRQ_THRESH.
REQ-029 SHALL deassert o_irq only through pops lowering the count, or per REQ-035.

Reset
REQ-030 SHALL, on i_rst=1 at a clock edge, set pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_irq=0 and the timeout counter=0.
REQ-031 SHALL, on reset mid-operation, discard all stored bytes and ignore a coincident i_din_valid or i_rd_en.
REQ-032 SHALL NOT reset storage RAM contents.

Configuration
REQ-033 SHALL, with macro UART_RX_TIMEOUT_EN defined, implement a timeout counter that increments on i_clken while o_empty=0.
REQ-034 SHALL, with UART_RX_TIMEOUT_EN defined, clear the timeout counter on any push or pop, or when empty.
REQ-035 SHALL, with UART_RX_TIMEOUT_EN defined, set a timeout flag when the counter reaches TIMEOUT_TICKS, OR it into o_irq, and clear it on the next pop or push.
REQ-036 SHALL, without UART_RX_TIMEOUT_EN, omit the counter, and o_irq SHALL equal the threshold term only.

Verification
REQ-037 SHALL cover: push 0x41, 0x42, 0x43, then pop x3 -> o_dout_8b 0x41, 0x42, 0x43 in order; o_empty=1 after the third pop, count 0.
REQ-038 SHALL cover: 17 pushes with no pops -> o_full=1 after 16, 17th dropped, o_overflow=1; i_clr_ovf -> o_overflow=0.
REQ-039 SHALL cover: fill to 16, then simultaneous push 0x55 and pop -> count stays 16, no overflow, 0x55 read as the last entry.
REQ-040 SHALL cover: 8 pushes -> o_irq=1 one cycle after the 8th; one pop -> o_irq=0; with timeout compiled out, o_irq stays 0 at count 7.
REQ-041 SHALL cover (UART_RX_TIMEOUT_EN): 1 push then 640 i_clken ticks -> o_irq=1; one pop -> o_irq=0, count 0.
REQ-042 SHALL cover: assert i_rst with count 5 and a coincident push -> next cycle count 0, o_empty=1, o_irq=0.
